onchip_memory_arbiter: RTL and testbench



---
 rtl/onchip_memory_arbiter_pkg.sv | 8 +
 rtl/onchip_memory_arbiter_rr_arbiter2.sv | 22 ++
 rtl/onchip_memory_arbiter.sv | 97 +++++++++
 tb/tb_onchip_memory_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared sizing constants for the two-master on-chip RAM arbiter.
package onchip_memory_arbiter_pkg;

    localparam int ADDR_W_DEF  = 2;
    localparam int DATA_W_DEF  = 32;
    localparam int NUM_MASTERS = 2;

endpackage

// File: rtl/onchip_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// master that was not granted last.
module rr_arbiter2
    import onchip_memory_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic                   i_last_grant,
    output logic [NUM_MASTERS-1:0] o_grant
);

    always_comb begin
        // NOTE: default assigned first so every path drives o_grant; no latch.
        o_grant = '0;
        unique case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Shares the single-port on-chip RAM between two Avalon-MM masters, one
// access per clock, read data returned one cycle after acceptance.
module onchip_memory_arbiter
    import onchip_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    output logic                m0_waitrequest,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic                m1_waitrequest,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic [NUM_MASTERS-1:0] w_req_raw;
    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_grant;
    logic [NUM_MASTERS-1:0] w_rd_only;
    logic                   w_sel_m1;

    logic r_last_grant;
    logic r_pending;
    logic r_owner;
    logic r_clken;

    assign w_req_raw = {m1_read | m1_write, m0_read | m0_write};
    assign w_rd_only = {m1_read & ~m1_write, m0_read & ~m0_write};
    // Requests are masked during reset so nothing is accepted in that cycle.
    assign w_req     = w_req_raw & {NUM_MASTERS{reset_n}};

    rr_arbiter2 u_rr_arbiter2 (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign w_sel_m1 = w_grant[1];

    // With no grant the address/data paths idle on the m0 values.
    assign mem_address    = w_sel_m1 ? m1_address    : m0_address;
    assign mem_byteenable = w_sel_m1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = w_sel_m1 ? m1_writedata  : m0_writedata;
    assign mem_write      = (w_grant[0] & m0_write) | (w_grant[1] & m1_write);
    assign mem_chipselect = |w_grant;
    assign mem_clken      = r_clken;

    assign m0_waitrequest = ~reset_n | (w_req_raw[0] & ~w_grant[0]);
    assign m1_waitrequest = ~reset_n | (w_req_raw[1] & ~w_grant[1]);

    // A read pending across an asserted reset is dropped, not returned.
    assign m0_readdatavalid = reset_n & r_pending & ~r_owner;
    assign m1_readdatavalid = reset_n & r_pending &  r_owner;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_pending    <= 1'b0;
            r_owner      <= 1'b0;
            r_clken      <= 1'b0;
        end else begin
            r_clken   <= 1'b1;
            r_pending <= |(w_grant & w_rd_only);
            if (|w_grant) begin
                r_last_grant <= w_sel_m1;
                r_owner      <= w_sel_m1;
            end
        end
    end

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed bench for onchip_memory_arbiter with a behavioural 4x32 RAM.
module tb_onchip_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        m0_waitrequest, m1_waitrequest;
    logic [1:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    logic [31:0] ram [4];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    onchip_memory_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m0_waitrequest   (m0_waitrequest),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .m1_waitrequest   (m1_waitrequest),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    // Single-port RAM with registered output, as seen on the s1 port.
    initial for (int k = 0; k < 4; k++) ram[k] = 32'h0;
    always @(posedge clk) begin
        if (mem_clken === 1'b1) begin
            if (mem_chipselect && mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // req = {m0_read, m0_write, m1_read, m1_write}
    // flg = {m0_wait, m1_wait, chipselect, mem_write, m0_rdv, m1_rdv}
    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [1:0]  m0_a;
        logic [3:0]  m0_be;
        logic [31:0] m0_wd;
        logic [1:0]  m1_a;
        logic [3:0]  m1_be;
        logic [31:0] m1_wd;
        logic [5:0]  flg;
        logic [1:0]  e_a;
        logic        e_ck;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt [13];

    task automatic drive(input vec_t v);
        reset_n       = v.rst_n;
        {m0_read, m0_write, m1_read, m1_write} = v.req;
        m0_address    = v.m0_a;
        m0_byteenable = v.m0_be;
        m0_writedata  = v.m0_wd;
        m1_address    = v.m1_a;
        m1_byteenable = v.m1_be;
        m1_writedata  = v.m1_wd;
    endtask

    task automatic set_idle();
        {m0_read, m0_write, m1_read, m1_write} = 4'b0000;
        m0_address = 2'd0; m1_address = 2'd0;
        m0_byteenable = 4'h0; m1_byteenable = 4'h0;
        m0_writedata = 32'h0; m1_writedata = 32'h0;
    endtask

    initial begin
        int g0, g1;
        logic exp_m0;

        vt[0]  = '{1'b1, 4'b0100, 2'd2, 4'hF, 32'hDEADBEEF, 2'd0, 4'h0, 32'h0,        6'b001100, 2'd2, 1'b1, 32'h0};
        vt[1]  = '{1'b1, 4'b0001, 2'd0, 4'h0, 32'h0,        2'd0, 4'hF, 32'hCAFEF00D, 6'b001100, 2'd0, 1'b1, 32'h0};
        vt[2]  = '{1'b1, 4'b1000, 2'd2, 4'h0, 32'h0,        2'd0, 4'h0, 32'h0,        6'b001000, 2'd2, 1'b1, 32'h0};
        vt[3]  = '{1'b1, 4'b0000, 2'd0, 4'h0, 32'h0,        2'd0, 4'h0, 32'h0,        6'b000010, 2'd0, 1'b1, 32'hDEADBEEF};
        vt[4]  = '{1'b1, 4'b0100, 2'd1, 4'hF, 32'h11223344, 2'd0, 4'h0, 32'h0,        6'b001100, 2'd1, 1'b1, 32'h0};
        vt[5]  = '{1'b1, 4'b0100, 2'd1, 4'h5, 32'hAABBCCDD, 2'd0, 4'h0, 32'h0,        6'b001100, 2'd1, 1'b1, 32'h0};
        vt[6]  = '{1'b1, 4'b1000, 2'd1, 4'h0, 32'h0,        2'd0, 4'h0, 32'h0,        6'b001000, 2'd1, 1'b1, 32'h0};
        vt[7]  = '{1'b1, 4'b1100, 2'd2, 4'hF, 32'h01020304, 2'd0, 4'h0, 32'h0,        6'b001110, 2'd2, 1'b1, 32'h11BB33DD};
        vt[8]  = '{1'b1, 4'b1000, 2'd0, 4'h0, 32'h0,        2'd0, 4'h0, 32'h0,        6'b001000, 2'd0, 1'b1, 32'h0};
        vt[9]  = '{1'b0, 4'b1010, 2'd0, 4'h0, 32'h0,        2'd0, 4'h0, 32'h0,        6'b110000, 2'd0, 1'b1, 32'h0};
        vt[10] = '{1'b1, 4'b1010, 2'd0, 4'h0, 32'h0,        2'd0, 4'h0, 32'h0,        6'b011000, 2'd0, 1'b0, 32'h0};
        vt[11] = '{1'b1, 4'b0010, 2'd0, 4'h0, 32'h0,        2'd0, 4'h0, 32'h0,        6'b001010, 2'd0, 1'b1, 32'hCAFEF00D};
        vt[12] = '{1'b1, 4'b0000, 2'd0, 4'h0, 32'h0,        2'd0, 4'h0, 32'h0,        6'b000001, 2'd0, 1'b1, 32'hCAFEF00D};

        reset_n = 1'b0;
        set_idle();

        // Reset for two edges, then release with no traffic.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            check($sformatf("rst%0d m0_wait", c), 32'(m0_waitrequest), 32'd1);
            check($sformatf("rst%0d m1_wait", c), 32'(m1_waitrequest), 32'd1);
            check($sformatf("rst%0d cs", c), 32'(mem_chipselect), 32'd0);
            check($sformatf("rst%0d rdv", c), 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
            check($sformatf("rst%0d clken", c), 32'(mem_clken), 32'd0);
        end
        reset_n = 1'b1;
        #1;
        check("rel m0_wait", 32'(m0_waitrequest), 32'd0);
        check("rel m1_wait", 32'(m1_waitrequest), 32'd0);
        check("rel clken", 32'(mem_clken), 32'd0);
        @(negedge clk); #1;
        check("idle clken", 32'(mem_clken), 32'd1);
        check("idle rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1;
            check($sformatf("v%0d m0_wait", i), 32'(m0_waitrequest),   32'(vt[i].flg[5]));
            check($sformatf("v%0d m1_wait", i), 32'(m1_waitrequest),   32'(vt[i].flg[4]));
            check($sformatf("v%0d cs", i),      32'(mem_chipselect),   32'(vt[i].flg[3]));
            check($sformatf("v%0d mem_wr", i),  32'(mem_write),        32'(vt[i].flg[2]));
            check($sformatf("v%0d m0_rdv", i),  32'(m0_readdatavalid), 32'(vt[i].flg[1]));
            check($sformatf("v%0d m1_rdv", i),  32'(m1_readdatavalid), 32'(vt[i].flg[0]));
            check($sformatf("v%0d mem_addr", i), 32'(mem_address),     32'(vt[i].e_a));
            check($sformatf("v%0d clken", i),   32'(mem_clken),        32'(vt[i].e_ck));
            if (vt[i].flg[1]) check($sformatf("v%0d m0_rdata", i), m0_readdata, vt[i].e_rd);
            if (vt[i].flg[0]) check($sformatf("v%0d m1_rdata", i), m1_readdata, vt[i].e_rd);
        end

        // Continuous contention: last grant was m1, so m0 leads and they alternate.
        g0 = 0; g1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_idle();
            m0_read = 1'b1; m0_address = 2'd2;
            m1_read = 1'b1; m1_address = 2'd1;
            #1;
            exp_m0 = (i % 2 == 0);
            check($sformatf("cont%0d m0_wait", i), 32'(m0_waitrequest), 32'(!exp_m0));
            check($sformatf("cont%0d m1_wait", i), 32'(m1_waitrequest), 32'(exp_m0));
            check($sformatf("cont%0d m0_rdv", i), 32'(m0_readdatavalid), 32'(i % 2 == 1));
            check($sformatf("cont%0d m1_rdv", i), 32'(m1_readdatavalid), 32'(i > 0 && i % 2 == 0));
            if (i % 2 == 1) check($sformatf("cont%0d m0_rdata", i), m0_readdata, 32'h01020304);
            if (i > 0 && i % 2 == 0) check($sformatf("cont%0d m1_rdata", i), m1_readdata, 32'h11BB33DD);
            if (!m0_waitrequest) g0++;
            if (!m1_waitrequest) g1++;
        end
        @(negedge clk);
        set_idle();
        #1;
        check("cont tail m1_rdv", 32'(m1_readdatavalid), 32'd1);
        check("cont tail m1_rdata", m1_readdata, 32'h11BB33DD);
        check("cont m0 grants", 32'(g0), 32'd4);
        check("cont m1 grants", 32'(g1), 32'd4);

        // m1 writes address 3, m0 reads it on the very next edge.
        @(negedge clk);
        m1_write = 1'b1; m1_address = 2'd3; m1_byteenable = 4'hF; m1_writedata = 32'h5A5A5A5A;
        #1;
        check("raw wr m1_wait", 32'(m1_waitrequest), 32'd0);
        @(negedge clk);
        set_idle();
        m0_read = 1'b1; m0_address = 2'd3;
        #1;
        check("raw rd m0_wait", 32'(m0_waitrequest), 32'd0);
        @(negedge clk);
        set_idle();
        #1;
        check("raw m0_rdv", 32'(m0_readdatavalid), 32'd1);
        check("raw m0_rdata", m0_readdata, 32'h5A5A5A5A);
        @(negedge clk); #1;
        check("raw rdv single", 32'(m0_readdatavalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
